// File: rtl/fme_pkg.sv
// Shared types, window geometry and FSM states for the half-pel window loader.
package fme_pkg;

    typedef logic [7:0] pix_t;

    localparam int WIN_W   = 16;
    localparam int WIN_PIX = WIN_W * WIN_W;

    typedef pix_t [8:0] half_vec_t;
    typedef pix_t [3:0] hpix_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        KICK,
        WAIT,
        OUT
    } state_t;

    // The 6-tap filter reaches up to 3 pixels away, so the centre must keep that clearance.
    function automatic logic idx_in_range(input logic [7:0] idx, input int margin);
        int row;
        int col;
        row = int'(idx[7:4]);
        col = int'(idx[3:0]);
        return (row >= margin) && (row <= WIN_W - 1 - margin) &&
               (col >= margin) && (col <= WIN_W - 1 - margin);
    endfunction

endpackage

// File: rtl/fme_win_loader_if.sv
// Bundle of job, pixel-stream, interpolator and result signals around the window loader.
interface fme_win_loader_if;
    import fme_pkg::*;

    logic       start;
    logic [7:0] ctr_idx;
    logic       in_valid;
    logic       in_ready;
    pix_t       in_pix;
    pix_t       lut [WIN_PIX-1:0];
    logic       ip_rst_n;
    logic [7:0] ip_ind;
    logic       ip_done;
    half_vec_t  ip_half;
    hpix_vec_t  ip_half_pix;
    logic       res_valid;
    logic       res_ready;
    half_vec_t  res_half;
    hpix_vec_t  res_half_pix;
    logic       res_err;
    logic       busy;

    modport master (
        input  start, ctr_idx, in_valid, in_pix, ip_done, ip_half, ip_half_pix, res_ready,
        output in_ready, lut, ip_rst_n, ip_ind, res_valid, res_half, res_half_pix, res_err, busy
    );

    modport slave (
        output start, ctr_idx, in_valid, in_pix, ip_done, ip_half, ip_half_pix, res_ready,
        input  in_ready, lut, ip_rst_n, ip_ind, res_valid, res_half, res_half_pix, res_err, busy
    );

endinterface

// File: rtl/fme_win_loader.sv
// Loads a 16x16 reference window, runs one half-pel interpolation per start and
// returns the captured candidates over a valid/ready handshake.
module fme_win_loader
    import fme_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int MARGIN  = 3
) (
    input  logic            clk,
    input  logic            rst,
    fme_win_loader_if.master bus
);

    localparam int             WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t         state;
    logic [7:0]     wr_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           beat;

    assign beat = bus.in_valid & bus.in_ready;

    // Flat register window: the interpolator reads many taps at once, so no RAM macro.
    always_ff @(posedge clk) begin
        if (beat) begin
            bus.lut[wr_cnt] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            bus.in_ready     <= 1'b0;
            bus.ip_rst_n     <= 1'b0;
            bus.ip_ind       <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_err      <= 1'b0;
            bus.res_half     <= '0;
            bus.res_half_pix <= '0;
            bus.busy         <= 1'b0;
            wr_cnt           <= '0;
            wait_cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.ip_rst_n <= 1'b0;
                    if (bus.start) begin
                        bus.ip_ind <= bus.ctr_idx;
                        bus.busy   <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (idx_in_range(bus.ip_ind, MARGIN)) begin
                        wr_cnt       <= '0;
                        bus.in_ready <= 1'b1;
                        state        <= LOAD;
                    end else begin
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        state         <= OUT;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wr_cnt <= wr_cnt + 8'd1;
                        if (wr_cnt == 8'(WIN_PIX - 1)) begin
                            bus.in_ready <= 1'b0;
                            state        <= KICK;
                        end
                    end
                end
                KICK: begin
                    bus.ip_rst_n <= 1'b1;
                    wait_cnt     <= '0;
                    state        <= WAIT;
                end
                // The interpolator goes back into reset on the same edge the result appears,
                // so res_* never changes while ip_rst_n is high.
                WAIT: begin
                    wait_cnt <= wait_cnt + WCW'(1);
                    if (bus.ip_done) begin
                        bus.res_half     <= bus.ip_half;
                        bus.res_half_pix <= bus.ip_half_pix;
                        bus.res_err      <= 1'b0;
                        bus.res_valid    <= 1'b1;
                        bus.ip_rst_n     <= 1'b0;
                        state            <= OUT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        bus.ip_rst_n  <= 1'b0;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    bus.ip_rst_n <= 1'b0;
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fme_win_loader.sv
// Randomised bench for fme_win_loader with a stub interpolator and a 6-tap reference model.
module tb_fme_win_loader;
    import fme_pkg::*;

    localparam int TIMEOUT = 63;
    localparam int MARGIN  = 3;
    localparam int LAT     = 28;

    typedef pix_t win_t [WIN_PIX-1:0];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fme_win_loader_if bus();

    fme_win_loader #(.TIMEOUT(TIMEOUT), .MARGIN(MARGIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    win_t pixels;
    logic never_done;
    logic done_r;
    int   lat_cnt;

    function automatic int tap6(input int a, input int b, input int c,
                                input int d, input int e, input int f);
        int s;
        s = a - 5 * b + 20 * c + 20 * d - 5 * e + f;
        s = (s + 16) >>> 5;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int hhalf(input win_t w, input int r, input int x0);
        int b;
        b = r * WIN_W + x0;
        return tap6(w[b-2], w[b-1], w[b], w[b+1], w[b+2], w[b+3]);
    endfunction

    function automatic int vhalf(input win_t w, input int c, input int y0);
        return tap6(w[(y0-2)*WIN_W+c], w[(y0-1)*WIN_W+c], w[y0*WIN_W+c],
                    w[(y0+1)*WIN_W+c], w[(y0+2)*WIN_W+c], w[(y0+3)*WIN_W+c]);
    endfunction

    // Candidate k = (dy+1)*3 + (dx+1): centre pixel, h/v half-pels, diagonals as their rounded mean.
    function automatic logic [103:0] interp(input win_t w, input logic [7:0] idx);
        half_vec_t h;
        hpix_vec_t p;
        int r, c, hx, vy, k;
        r = int'(idx[7:4]);
        c = int'(idx[3:0]);
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                k  = (dy + 1) * 3 + (dx + 1);
                hx = hhalf(w, r, (dx < 0) ? c - 1 : c);
                vy = vhalf(w, c, (dy < 0) ? r - 1 : r);
                if (dx == 0 && dy == 0)  h[k] = w[r*WIN_W+c];
                else if (dy == 0)        h[k] = 8'(hx);
                else if (dx == 0)        h[k] = 8'(vy);
                else                     h[k] = 8'((hx + vy + 1) / 2);
            end
        end
        p[0] = w[(r-1)*WIN_W+c];
        p[1] = w[(r+1)*WIN_W+c];
        p[2] = w[r*WIN_W+c-1];
        p[3] = w[r*WIN_W+c+1];
        return {h, p};
    endfunction

    function automatic bit in_window(input logic [7:0] idx);
        int r, c;
        r = idx / 16;
        c = idx % 16;
        return r >= MARGIN && r <= 15 - MARGIN && c >= MARGIN && c <= 15 - MARGIN;
    endfunction

    // Stub interpolator: done is sticky while released, cleared as soon as ip_rst_n drops.
    assign bus.ip_done = done_r && bus.ip_rst_n;

    always @(posedge clk) begin
        if (!bus.ip_rst_n) begin
            lat_cnt <= 0;
            done_r  <= 1'b0;
        end else if (!never_done) begin
            if (lat_cnt == LAT - 1) begin
                done_r <= 1'b1;
                {bus.ip_half, bus.ip_half_pix} <= interp(bus.lut, bus.ip_ind);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    task automatic check_output(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_in_ready"},  bus.in_ready, 0);
        check_output({tag, "_ip_rst_n"},  bus.ip_rst_n, 0);
        check_output({tag, "_ip_ind"},    bus.ip_ind, 0);
        check_output({tag, "_res_valid"}, bus.res_valid, 0);
        check_output({tag, "_res_err"},   bus.res_err, 0);
        check_output({tag, "_res_data"},  {bus.res_half, bus.res_half_pix}, 0);
        check_output({tag, "_busy"},      bus.busy, 0);
    endtask

    // Runs one job from a negedge; abort_at >= 0 stops after that many beats for a reset test.
    task automatic apply_stimulus(input logic [7:0] ctr, input bit ramp, input bit gaps,
                                  input int ready_delay, input bit no_done,
                                  input bit pulse_start, input int abort_at);
        bit        expect_ok, got_res, finished, drv_valid, ready_prev, changed, ready_seen, late;
        int        beats, last_beat_cyc, rise_cyc, rst_high, ready_cycles, hold_wait, nmis;
        half_vec_t snap_h;
        hpix_vec_t snap_p;
        logic      snap_err;

        expect_ok = in_window(ctr);
        for (int i = 0; i < WIN_PIX; i++) pixels[i] = ramp ? 8'(i) : 8'($urandom);
        never_done = no_done;
        got_res = 0; finished = 0; drv_valid = 0; ready_prev = 0; changed = 0;
        ready_seen = 0; late = 0; beats = 0; last_beat_cyc = -1; rise_cyc = -1;
        rst_high = 0; ready_cycles = 0; hold_wait = 0; nmis = 0;
        snap_h = '0; snap_p = '0; snap_err = 1'b0;

        bus.start   = 1'b1;
        bus.ctr_idx = ctr;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.ctr_idx = 8'($urandom);

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (drv_valid && ready_prev) begin
                beats++;
                last_beat_cyc = cyc;
            end
            if (abort_at >= 0 && beats >= abort_at) begin
                finished = 1; bus.in_valid = 1'b0; drv_valid = 0; bus.start = 1'b0;
            end else if (bus.res_ready) begin
                bus.res_ready = 1'b0; bus.start = 1'b0; finished = 1;
                check_output("accept_valid", bus.res_valid, 0);
                check_output("accept_busy", bus.busy, 0);
            end else begin
                if (bus.in_ready) begin ready_seen = 1; ready_cycles++; end
                if (bus.ip_rst_n) begin
                    rst_high++;
                    if (rise_cyc < 0) rise_cyc = cyc;
                end
                if (bus.res_valid) begin
                    if (!got_res) begin
                        got_res = 1; snap_h = bus.res_half; snap_p = bus.res_half_pix;
                        snap_err = bus.res_err; hold_wait = ready_delay;
                        check_output("out_busy", bus.busy, 1);
                        check_output("out_ip_rst_n", bus.ip_rst_n, 0);
                        check_output("ip_ind", bus.ip_ind, ctr);
                    end else if ({bus.res_half, bus.res_half_pix, bus.res_err} !==
                                 {snap_h, snap_p, snap_err}) begin
                        changed = 1;
                    end
                    if (hold_wait == 0) bus.res_ready = 1'b1;
                    else hold_wait--;
                end
                bus.in_valid = (beats < WIN_PIX) && (!gaps || $urandom_range(0, 1) == 1);
                drv_valid    = bus.in_valid;
                bus.in_pix   = pixels[beats % WIN_PIX];
                ready_prev   = bus.in_ready;
                bus.start    = pulse_start && (bus.in_ready || bus.ip_rst_n) &&
                               ($urandom_range(0, 3) == 0);
                if (bus.start) bus.ctr_idx = 8'($urandom);
            end
            @(negedge clk);
        end

        if (abort_at >= 0) begin
            check_output("abort_beats", beats, abort_at);
            return;
        end
        if (!finished) check_output("job_finished", 0, 1);
        check_output("beats", beats, expect_ok ? WIN_PIX : 0);
        check_output("res_err", snap_err, (!expect_ok || no_done) ? 1 : 0);
        check_output("res_hold", changed, 0);
        if (expect_ok) begin
            check_output("kick_delay", rise_cyc - last_beat_cyc, 1);
            if (!gaps) check_output("ready_cycles", ready_cycles, WIN_PIX);
            for (int i = 0; i < WIN_PIX; i++) if (bus.lut[i] !== pixels[i]) nmis++;
            check_output("lut_mismatches", nmis, 0);
            if (no_done) begin
                check_output("timeout_cycles", rst_high, TIMEOUT);
            end else begin
                check_output("res_data", {snap_h, snap_p}, interp(pixels, ctr));
                if (ramp) check_output("centre", snap_h[4], ctr);
            end
        end else begin
            check_output("range_ready_seen", ready_seen, 0);
            check_output("range_ip_rst_n", rst_high, 0);
        end
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid) late = 1;
        end
        check_output("single_result", late, 0);
    endtask

    initial begin
        int       r, c;
        logic [7:0] ctr;
        rst = 1'b0;
        bus.start = 1'b0; bus.ctr_idx = '0; bus.in_valid = 1'b0; bus.in_pix = '0;
        bus.res_ready = 1'b0; never_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        apply_stimulus(8'h77, 1, 0, 0, 0, 0, -1);
        apply_stimulus(8'h77, 1, 1, 10, 0, 0, -1);
        apply_stimulus(8'h02, 0, 0, 0, 0, 0, -1);
        apply_stimulus(8'hD5, 0, 0, 2, 0, 0, -1);
        apply_stimulus(8'h55, 0, 1, 2, 1, 0, -1);

        apply_stimulus(8'h66, 0, 0, 0, 0, 0, 100);
        rst = 1'b0;
        #1;
        check_reset("midjob_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        apply_stimulus(8'h66, 0, 0, 0, 0, 0, -1);

        apply_stimulus(8'h88, 0, 1, 3, 0, 1, -1);

        repeat (8) begin
            if ($urandom_range(0, 3) != 0) begin
                r   = $urandom_range(MARGIN, 15 - MARGIN);
                c   = $urandom_range(MARGIN, 15 - MARGIN);
                ctr = 8'(r * 16 + c);
            end else begin
                ctr = 8'($urandom);
            end
            apply_stimulus(ctr, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
                           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
